ibex_hpm_event_ctrl: RTL and testbench

IBEX_HPM_EVENT_CTRL -- requirements
Module: ibex_hpm_event_ctrl

---
 rtl/ibex_hpm_event_ctrl.sv | 125 ++++++++++++
 tb/tb_ibex_hpm_event_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_hpm_event_ctrl.sv
// Performance-counter event routing: mcountinhibit, mhpmevent selects and counter write strobes.
// Define IBEX_HPM_EVENT_WRITABLE_EN for writable mhpmevent selects (default: hardwired one-hot).
module ibex_hpm_event_ctrl #(
    parameter int unsigned MHPMCounterNum = 2,
    parameter int unsigned NumEvents      = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           csr_we_i,
    input  logic [11:0]                    csr_addr_i,
    input  logic [31:0]                    csr_wdata_i,
    input  logic [NumEvents-1:0]           events_i,
    output logic [31:0]                    csr_rdata_o,
    output logic                           csr_hit_o,
    output logic [MHPMCounterNum+3-1:0]    counter_inc_o,
    output logic [MHPMCounterNum+3-1:0]    counter_we_o,
    output logic [MHPMCounterNum+3-1:0]    counterh_we_o,
    output logic [31:0]                    counter_val_o
);

    localparam int unsigned NC     = MHPMCounterNum + 3;
    localparam int unsigned NumHpm = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;
    // The time slot has no counter, so its inhibit bit always reads 0.
    localparam logic [NC-1:0] InhibitMask = {{(NC - 2){1'b1}}, 2'b01};

    logic [NumEvents-1:0] event_q;
    logic [NC-1:0]        inhibit_q, inhibit_d;
    logic [NumEvents-1:0] mhpmevent [NumHpm];

    always_comb begin
        inhibit_d = inhibit_q;
        if (csr_we_i && (csr_addr_i == 12'h320)) begin
            inhibit_d = csr_wdata_i[NC-1:0] & InhibitMask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_q   <= '0;
            inhibit_q <= '0;
        end else begin
            event_q   <= events_i;
            inhibit_q <= inhibit_d;
        end
    end

`ifdef IBEX_HPM_EVENT_WRITABLE_EN
    logic [NumEvents-1:0] mhpmevent_q [NumHpm];
    logic [NumEvents-1:0] mhpmevent_d [NumHpm];

    always_comb begin
        for (int k = 0; k < NumHpm; k++) begin
            mhpmevent_d[k] = mhpmevent_q[k];
            if (csr_we_i && (k < MHPMCounterNum) && (csr_addr_i == 12'h323 + 12'(k))) begin
                mhpmevent_d[k] = csr_wdata_i[NumEvents-1:0];
            end
            mhpmevent[k] = mhpmevent_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumHpm; k++) begin
                mhpmevent_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumHpm; k++) begin
                mhpmevent_q[k] <= mhpmevent_d[k];
            end
        end
    end
`else
    // Counter 3+k is wired to HPM event k, which sits at events_i bit 2+k.
    always_comb begin
        for (int k = 0; k < NumHpm; k++) begin
            mhpmevent[k] = '0;
        end
        for (int k = 0; k < MHPMCounterNum; k++) begin
            mhpmevent[k][2+k] = 1'b1;
        end
    end
`endif

    // Increments come only from flops so no input reaches counter_inc_o combinationally.
    always_comb begin
        counter_inc_o    = '0;
        counter_inc_o[0] = event_q[0] & ~inhibit_q[0];
        counter_inc_o[2] = event_q[1] & ~inhibit_q[2];
        for (int k = 0; k < MHPMCounterNum; k++) begin
            counter_inc_o[3+k] = (|(event_q & mhpmevent[k])) & ~inhibit_q[3+k];
        end
    end

    always_comb begin
        csr_rdata_o   = '0;
        csr_hit_o     = 1'b0;
        counter_we_o  = '0;
        counterh_we_o = '0;
        if (csr_addr_i == 12'h320) begin
            csr_hit_o             = 1'b1;
            csr_rdata_o[NC-1:0]   = inhibit_q;
        end
        for (int k = 0; k < MHPMCounterNum; k++) begin
            if (csr_addr_i == 12'h323 + 12'(k)) begin
                csr_hit_o                  = 1'b1;
                csr_rdata_o[NumEvents-1:0] = mhpmevent[k];
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (i != 1) begin
                if (csr_addr_i == 12'hB00 + 12'(i)) begin
                    csr_hit_o       = 1'b1;
                    counter_we_o[i] = csr_we_i;
                end
                if (csr_addr_i == 12'hB80 + 12'(i)) begin
                    csr_hit_o        = 1'b1;
                    counterh_we_o[i] = csr_we_i;
                end
            end
        end
    end

    assign counter_val_o = csr_wdata_i;

endmodule

// File: tb/tb_ibex_hpm_event_ctrl.sv
// Directed bench for ibex_hpm_event_ctrl with MHPMCounterNum=2, NumEvents=8.
module tb_ibex_hpm_event_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [7:0]  events_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic [4:0]  counter_inc_o;
    logic [4:0]  counter_we_o;
    logic [4:0]  counterh_we_o;
    logic [31:0] counter_val_o;

    int vectors     = 0;
    int miscompares = 0;

    ibex_hpm_event_ctrl #(
        .MHPMCounterNum(2),
        .NumEvents     (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .csr_we_i     (csr_we_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .events_i     (events_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_hit_o    (csr_hit_o),
        .counter_inc_o(counter_inc_o),
        .counter_we_o (counter_we_o),
        .counterh_we_o(counterh_we_o),
        .counter_val_o(counter_val_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr_we_i   = 1'b0;
        csr_addr_i = addr;
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        csr_we_i    = 1'b0;
        csr_addr_i  = 12'h000;
        csr_wdata_i = 32'h0;
        events_i    = 8'h01;
        step();
        step();
        chk("inc_in_reset", 32'(counter_inc_o), 32'h0);
        rd(12'h320);
        chk("inhibit_reset", csr_rdata_o, 32'h0);
        rd(12'h323);
`ifdef IBEX_HPM_EVENT_WRITABLE_EN
        chk("mhpmevent3_reset", csr_rdata_o, 32'h0);
`else
        chk("mhpmevent3_reset", csr_rdata_o, 32'h4);
`endif

        // Release reset: first cycle has no increment, then mcycle every cycle.
        rst_ni = 1'b1;
        #1;
        chk("inc_first_cycle", 32'(counter_inc_o), 32'h0);
        step();
        chk("inc_cycle_1", 32'(counter_inc_o), 32'h01);
        step();
        chk("inc_cycle_2", 32'(counter_inc_o), 32'h01);

        events_i = 8'h03;
        step();
        chk("inc_cyc_instret", 32'(counter_inc_o), 32'h05);

        csr_addr_i  = 12'h320;
        csr_wdata_i = 32'h5;
        csr_we_i    = 1'b1;
        #1;
        chk("inhibit_hit", 32'(csr_hit_o), 32'h1);
        chk("inhibit_not_yet", 32'(counter_inc_o), 32'h05);
        step();
        csr_we_i = 1'b0;
        #1;
        chk("inhibited_inc", 32'(counter_inc_o), 32'h0);
        rd(12'h320);
        chk("inhibit_read_5", csr_rdata_o, 32'h5);

        csr_wdata_i = 32'hFFFF_FFFF;
        csr_we_i    = 1'b1;
        step();
        rd(12'h320);
        chk("inhibit_read_all", csr_rdata_o, 32'h1D);
        csr_wdata_i = 32'h0;
        csr_we_i    = 1'b1;
        step();
        rd(12'h320);
        chk("inhibit_cleared", csr_rdata_o, 32'h0);
        chk("inc_resumed", 32'(counter_inc_o), 32'h05);

        rd(12'h325);
        chk("hit_mhpmevent5", 32'(csr_hit_o), 32'h0);
        chk("rdata_unowned", csr_rdata_o, 32'h0);

        events_i    = 8'h00;
        csr_addr_i  = 12'h323;
        csr_wdata_i = 32'h30;
        csr_we_i    = 1'b1;
        step();
        rd(12'h323);
        chk("hit_mhpmevent3", 32'(csr_hit_o), 32'h1);
`ifdef IBEX_HPM_EVENT_WRITABLE_EN
        chk("mhpmevent3_read", csr_rdata_o, 32'h30);
        rd(12'h324);
        chk("mhpmevent4_read", csr_rdata_o, 32'h0);
        events_i = 8'h20;
        step();
        events_i = 8'h00;
        #1;
        chk("hpm3_pulse", 32'(counter_inc_o), 32'h08);
        step();
        chk("hpm3_pulse_end", 32'(counter_inc_o), 32'h0);
`else
        chk("mhpmevent3_read", csr_rdata_o, 32'h4);
        rd(12'h324);
        chk("mhpmevent4_read", csr_rdata_o, 32'h8);
        events_i = 8'h04;
        step();
        events_i = 8'h08;
        #1;
        chk("hpm3_pulse", 32'(counter_inc_o), 32'h08);
        step();
        events_i = 8'h00;
        #1;
        chk("hpm4_pulse", 32'(counter_inc_o), 32'h10);
        step();
        chk("hpm_pulse_end", 32'(counter_inc_o), 32'h0);
`endif

        // Counter write strobes are combinational on the write cycle.
        csr_addr_i  = 12'hB82;
        csr_wdata_i = 32'hDEAD_BEEF;
        csr_we_i    = 1'b1;
        #1;
        chk("b82_hwe", 32'(counterh_we_o), 32'h04);
        chk("b82_we", 32'(counter_we_o), 32'h0);
        chk("b82_val", counter_val_o, 32'hDEAD_BEEF);
        chk("b82_hit", 32'(csr_hit_o), 32'h1);
        csr_addr_i = 12'hB01;
        #1;
        chk("b01_hit", 32'(csr_hit_o), 32'h0);
        chk("b01_en", {counter_we_o, counterh_we_o}, 32'h0);
        csr_addr_i = 12'hB04;
        #1;
        chk("b04_we", 32'(counter_we_o), 32'h10);
        csr_addr_i = 12'hB05;
        #1;
        chk("b05_hit", 32'(csr_hit_o), 32'h0);
        chk("b05_en", {counter_we_o, counterh_we_o}, 32'h0);
        csr_addr_i = 12'hB00;
        csr_we_i   = 1'b0;
        #1;
        chk("b00_no_we", 32'(counter_we_o), 32'h0);
        chk("b00_hit", 32'(csr_hit_o), 32'h1);

        // Asynchronous reset mid-cycle while mhpmcounter3 is incrementing.
`ifdef IBEX_HPM_EVENT_WRITABLE_EN
        events_i = 8'h20;
`else
        events_i = 8'h04;
`endif
        step();
        chk("hpm3_held", 32'(counter_inc_o), 32'h08);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset_inc", 32'(counter_inc_o), 32'h0);
        rd(12'h323);
`ifdef IBEX_HPM_EVENT_WRITABLE_EN
        chk("async_reset_evt", csr_rdata_o, 32'h0);
`else
        chk("async_reset_evt", csr_rdata_o, 32'h4);
`endif
        step();
        rst_ni = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
